// File: rtl/word_frame_tx.sv
// word_frame_tx: serial framer (start, WIDTH data bits LSB first, optional parity, stop bits); parity enabled by WORD_FRAME_TX_PARITY_EN
module word_frame_tx #(
    parameter int WIDTH        = 6,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             busy,
    output logic             frame_done
);
    localparam int DW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef WORD_FRAME_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
`ifdef WORD_FRAME_TX_PARITY_EN
    logic             parity;
`endif

    logic          div_end, enter_stop, stop_end, in_stop_next, done_next;
    logic [BW-1:0] stop_idx_next;
    logic [DW-1:0] div_next;

    // Look one cycle ahead so frame_done can be registered yet land on the final stop cycle
    always_comb begin
        div_end       = div_cnt == DIV_LAST;
        div_next      = div_end ? '0 : div_cnt + 1'b1;
`ifdef WORD_FRAME_TX_PARITY_EN
        enter_stop    = state == PARITY && div_end;
`else
        enter_stop    = state == DATA && div_end && bit_cnt == BIT_LAST;
`endif
        stop_end      = state == STOP && div_end && bit_cnt == STOP_LAST;
        in_stop_next  = enter_stop || (state == STOP && !stop_end);
        stop_idx_next = state != STOP ? '0 : div_end ? bit_cnt + 1'b1 : bit_cnt;
        done_next     = in_stop_next && stop_idx_next == STOP_LAST && div_next == DIV_LAST;
    end

    // Frame sequencer; every output is driven straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            ser_out    <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef WORD_FRAME_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            frame_done <= done_next;
            if (state != IDLE)
                div_cnt <= div_next;
            case (state)
                IDLE: begin
                    ser_out <= 1'b1;
                    if (in_valid && in_ready) begin
                        state    <= START;
                        shreg    <= in_data;
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                        ser_out  <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef WORD_FRAME_TX_PARITY_EN
                        parity   <= ^in_data;
`endif
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                START: if (div_end) begin
                    state   <= DATA;
                    ser_out <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= '0;
                end
                DATA: if (div_end) begin
                    if (bit_cnt == BIT_LAST) begin
`ifdef WORD_FRAME_TX_PARITY_EN
                        state   <= PARITY;
                        ser_out <= parity;
`else
                        state   <= STOP;
                        ser_out <= 1'b1;
`endif
                        bit_cnt <= '0;
                    end else begin
                        ser_out <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef WORD_FRAME_TX_PARITY_EN
                PARITY: if (div_end) begin
                    state   <= STOP;
                    ser_out <= 1'b1;
                    bit_cnt <= '0;
                end
`endif
                STOP: if (div_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_word_frame_tx.sv
// tb_word_frame_tx: directed checks of word_frame_tx framing, handshake, timing and reset
module tb_word_frame_tx;
`ifdef WORD_FRAME_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int N1 = (1 + 6 + P + 1) * 4;
    localparam int N2 = (1 + 6 + P + 2) * 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] in_data = '0, d2_data = '0;
    logic       in_valid = 1'b0, d2_valid = 1'b0;
    logic       in_ready, ser_out, busy, frame_done;
    logic       d2_ready, d2_ser, d2_busy, d2_done;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    word_frame_tx #(.WIDTH(6), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .busy(busy), .frame_done(frame_done)
    );

    word_frame_tx #(.WIDTH(6), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(d2_data), .in_valid(d2_valid),
        .in_ready(d2_ready), .ser_out(d2_ser), .busy(d2_busy), .frame_done(d2_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // expected line level in cycle k (1-based from acceptance) for c clks per bit
    function automatic logic exp_bit(input logic [5:0] w, input int k, input int c);
        int idx;
        idx = (k - 1) / c;
        if (idx == 0) return 1'b0;
        if (idx <= 6) return w[idx-1];
        if (P == 1 && idx == 7) return ^w;
        return 1'b1;
    endfunction

    // called at a negedge; checks a whole frame on dut plus the idle cycle after it
    task automatic run_frame(input logic [5:0] w, input logic [5:0] nxt, input logic keep);
        int t;
        t = 0;
        in_data = w;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", 32'(t < 200), 1);
        @(posedge clk);
        #1;
        in_data = nxt;
        in_valid = keep;
        for (int k = 1; k <= N1; k++) begin
            @(negedge clk);
            chk($sformatf("ser_%0h_c%0d", w, k), 32'(ser_out), 32'(exp_bit(w, k, 4)));
            chk($sformatf("done_%0h_c%0d", w, k), 32'(frame_done), 32'(k == N1));
            chk($sformatf("ready_%0h_c%0d", w, k), 32'(in_ready), 0);
            chk($sformatf("busy_%0h_c%0d", w, k), 32'(busy), 1);
        end
        @(negedge clk);
        chk("gap_ready", 32'(in_ready), 1);
        chk("gap_ser", 32'(ser_out), 1);
        chk("gap_busy", 32'(busy), 0);
        chk("gap_done", 32'(frame_done), 0);
    endtask

    initial begin
        #21;
        chk("rst_ser", 32'(ser_out), 1);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_ser2", 32'(d2_ser), 1);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(in_ready), 1);
            chk("idle_ser", 32'(ser_out), 1);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_done", 32'(frame_done), 0);
        end
        run_frame(6'h2D, 6'h00, 1'b0);
        run_frame(6'h01, 6'h00, 1'b0);
        run_frame(6'h15, 6'h2A, 1'b1);
        run_frame(6'h2A, 6'h00, 1'b0);
        d2_data = 6'h3F;
        d2_valid = 1'b1;
        chk("d2_ready", 32'(d2_ready), 1);
        @(posedge clk);
        #1 d2_valid = 1'b0;
        for (int k = 1; k <= N2; k++) begin
            @(negedge clk);
            chk($sformatf("d2_ser_c%0d", k), 32'(d2_ser), 32'(exp_bit(6'h3F, k, 1)));
            chk($sformatf("d2_done_c%0d", k), 32'(d2_done), 32'(k == N2));
        end
        @(negedge clk);
        chk("d2_gap_ready", 32'(d2_ready), 1);
        chk("d2_gap_done", 32'(d2_done), 0);
        in_data = 6'h2D;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (18) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_ser", 32'(ser_out), 1);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_ready", 32'(in_ready), 0);
        chk("mid_done", 32'(frame_done), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_hold_done", 32'(frame_done), 0);
            chk("mid_hold_ser", 32'(ser_out), 1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", 32'(frame_done), 0);
        run_frame(6'h12, 6'h00, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
